// File: rtl/aes_128_in_loader.sv
// Load stage for aes_128: assembles a 32-bit key/plaintext word stream into held 128-bit key/in_bus blocks.
// Optional build macro AES_KEY_REUSE_EN adds s_key_keep to reuse the previous key for 4-word jobs.
`timescale 1ns/1ps

module aes_128_in_loader #(
  parameter bit MSW_FIRST = 1'b1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [31:0]  s_data,
  input  logic         s_valid,
  output logic         s_ready,
`ifdef AES_KEY_REUSE_EN
  input  logic         s_key_keep,
`endif
  output logic [127:0] in_bus,
  output logic [127:0] key,
  output logic         blk_valid,
  input  logic         blk_ready,
  output logic [7:0]   blk_cnt
);

  typedef enum logic [1:0] {
    LOAD_KEY  = 2'd0,
    LOAD_DATA = 2'd1,
    HOLD      = 2'd2
  } state_t;

  state_t      state;
  logic [1:0]  cnt;
  logic [31:0] key_sh [4];
  // d3 goes straight from s_data into in_bus, so only three data words need staging.
  logic [31:0] dat_sh [3];
  logic        xfer;
  logic        key_skip;

  function automatic logic [127:0] pack_words(input logic [31:0] w0, w1, w2, w3);
    return MSW_FIRST ? {w0, w1, w2, w3} : {w3, w2, w1, w0};
  endfunction

  // Decoded from state only, so no input reaches an output combinationally.
  assign s_ready = (state != HOLD);
  assign xfer    = s_valid && s_ready;

`ifdef AES_KEY_REUSE_EN
  logic key_loaded;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key_loaded <= 1'b0;
    end else if (state == LOAD_DATA && xfer && cnt == 2'd3) begin
      key_loaded <= 1'b1;
    end
  end

  assign key_skip = s_key_keep && key_loaded && (cnt == 2'd0);
`else
  assign key_skip = 1'b0;
`endif

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= LOAD_KEY;
      cnt       <= 2'd0;
      in_bus    <= '0;
      key       <= '0;
      blk_valid <= 1'b0;
      blk_cnt   <= 8'd0;
      // NOTE: the shadow word arrays are reset too, so an aborted job leaves no residue behind.
      for (int i = 0; i < 4; i++) key_sh[i] <= '0;
      for (int i = 0; i < 3; i++) dat_sh[i] <= '0;
    end else begin
      case (state)
        LOAD_KEY: begin
          if (xfer) begin
            if (key_skip) begin
              dat_sh[0] <= s_data;
              cnt       <= 2'd1;
              state     <= LOAD_DATA;
            end else begin
              key_sh[cnt] <= s_data;
              cnt         <= cnt + 2'd1;
              if (cnt == 2'd3) state <= LOAD_DATA;
            end
          end
        end
        LOAD_DATA: begin
          if (xfer) begin
            if (cnt == 2'd3) begin
              key       <= pack_words(key_sh[0], key_sh[1], key_sh[2], key_sh[3]);
              in_bus    <= pack_words(dat_sh[0], dat_sh[1], dat_sh[2], s_data);
              blk_valid <= 1'b1;
              cnt       <= 2'd0;
              state     <= HOLD;
            end else begin
              dat_sh[cnt] <= s_data;
              cnt         <= cnt + 2'd1;
            end
          end
        end
        HOLD: begin
          if (blk_ready) begin
            blk_valid <= 1'b0;
            blk_cnt   <= blk_cnt + 8'd1;
            state     <= LOAD_KEY;
          end
        end
        default: begin
          state <= LOAD_KEY;
          cnt   <= 2'd0;
        end
      endcase
    end
  end

endmodule

// File: doc/aes_128_in_loader.md
# aes_128_in_loader

Upstream load stage for `aes_128`. It accepts a 32-bit valid/ready word stream carrying cipher key and plaintext. It assembles the words into 128-bit `in_bus` and `key` registers and presents them to `aes_128` as a held, handshaked block. Both outputs stay stable for as long as the block is pending, so the combinational `out_bus` of `aes_128` can be sampled downstream while `blk_valid` is high.

## Interface
- `MSW_FIRST`, default 1: 1 places word k (0..3) of a field at bits [127-32k -: 32]; 0 places it at [32k +: 32].
- `clk`  input  1  single clock; all flops on its rising edge.
- `rst_n`  input  1  asynchronous, active-low reset.
- `s_data`  input  32  stream word.
- `s_valid`  input  1  `s_data` valid.
- `s_ready`  output  1  loader accepts a word this cycle. A word transfers when `s_valid && s_ready`.
- `s_key_keep`  input  1  only present with `AES_KEY_REUSE_EN`. Sampled on the first word of a job.
- `in_bus`  output  128  plaintext to `aes_128`.
- `key`  output  128  cipher key to `aes_128`.
- `blk_valid`  output  1  `in_bus`/`key` hold a complete block.
- `blk_ready`  input  1  consumer has taken the block. Completes when `blk_valid && blk_ready`.
- `blk_cnt`  output  8  count of completed block handshakes, wraps 255→0.

## Operation
- A job is 8 accepted words: 4 key words (k0..k3), then 4 plaintext words (d0..d3), each placed per `MSW_FIRST`.
- Words go into shadow registers `key_sh` and `dat_sh`. The visible `in_bus`/`key` change only at block boundaries.
- FSM states:
  - LOAD_KEY (`cnt` 0..3)
  - LOAD_DATA (`cnt` 0..3)
  - HOLD
- 2-bit word counter `cnt`.
- LOAD_KEY: `s_ready`=1. On each transfer, write `key_sh[cnt]` and increment `cnt`. At `cnt`=3, go to LOAD_DATA with `cnt`=0.
- LOAD_DATA: `s_ready`=1. On each transfer, write `dat_sh[cnt]`. On the transfer at `cnt`=3:
  - copy `key_sh`→`key` and {`dat_sh`, `s_data`}→`in_bus` in that same edge;
  - set `blk_valid`=1;
  - go to HOLD.
- HOLD: `s_ready`=0. `in_bus`, `key` and `blk_valid` are held. On `blk_ready`:
  - clear `blk_valid`;
  - increment `blk_cnt`;
  - go to LOAD_KEY with `cnt`=0.
- `in_bus` and `key` keep their last values after the handshake, until the next block completes.
- `s_ready` is a pure decode of state: LOAD_* → 1, HOLD → 0. It does not depend on `blk_ready`, so nothing is combinational from input to output.
- `s_valid` deasserting mid-job pauses the load. The FSM and `cnt` hold, with no timeout.

## Timing
- Reset values:
  - `in_bus`=0, `key`=0, shadows=0
  - `blk_valid`=0, `blk_cnt`=0
  - state LOAD_KEY, `cnt`=0, so `s_ready`=1 during and after reset
- Latency: `blk_valid` rises on the edge that accepts d3, i.e. visible 1 cycle after d3 is presented.
- Minimum job period is 9 cycles: 8 words plus at least 1 HOLD cycle. The first word of the next job is accepted the cycle after the block handshake.
- `blk_ready` high while not in HOLD has no effect.
- Reset asserted mid-job or in HOLD aborts it. Partial words are discarded and all registers return to reset values immediately, without waiting for an edge.
- Deasserting `s_valid` or changing `s_data` while `s_ready`=0 is legal and ignored.

## Configuration
- `AES_KEY_REUSE_EN` defined:
  - the `s_key_keep` port exists;
  - an internal `key_loaded` flag is set on the first completed block and cleared by reset.
  - On a transfer in LOAD_KEY with `cnt`=0, `s_key_keep`=1 and `key_loaded`=1, that word is d0: the FSM goes to LOAD_DATA with `cnt`=1 and `key_sh` is retained. A job is then 4 words.
  - `s_key_keep` is ignored on any other word, or while `key_loaded`=0.
- `AES_KEY_REUSE_EN` not defined: the port is absent and every job is exactly 8 words.

## Test plan
- FIPS-197 C.1, with `MSW_FIRST`=1, `blk_ready`=1 and `s_valid` constant.
  - Stimulus: words 00010203, 04050607, 08090a0b, 0c0d0e0f, 00112233, 44556677, 8899aabb, ccddeeff.
  - Required: `key`=000102030405060708090a0b0c0d0e0f and `in_bus`=00112233445566778899aabbccddeeff, with `blk_valid` high 1 cycle after the 8th word.
  - Required: `aes_128` `out_bus`=69c4e0d86a7b0430d8cdb78070b4c55a, and `blk_cnt`=1.
- Backpressure: hold `blk_ready`=0 for 5 cycles in HOLD → `s_ready`=0, no word consumed, `in_bus`/`key` bit-stable, `blk_cnt` unchanged. Then `blk_ready`=1 → next word is accepted the following cycle as k0.
- `MSW_FIRST`=0 with the same words → `key`=0c0d0e0f08090a0b0405060700010203. A bench with 2 idle `s_valid` gaps mid-job gives an identical result.
- Reset pulse after 3 key words → all outputs 0 at once. A fresh 8-word job then loads correctly, with no residue from the aborted words.
- With `AES_KEY_REUSE_EN`: after the C.1 job, send 4 data words with `s_key_keep`=1 on the first → `key` is unchanged and `in_bus` is updated after 4 words. With `s_key_keep`=1 straight after reset, 8 words are still required.
- 256 back-to-back jobs → `blk_cnt` wraps to 0, with no dropped words.
